// File: rtl/replica_pkg.sv
// rtl/replica_pkg.sv - shared types and constants for the replica node array and its sequencer
package replica_pkg;

  localparam int EXP_RECIP_W   = 17;
  localparam int EXP_TERMS_MAX = 16;

  typedef enum logic [2:0] {
    IDLE,
    OPT,
    DIST,
    EINIT,
    ERUN,
    EFIN,
    EXCH,
    CHECK
  } seq_state_t;

  function automatic logic [EXP_RECIP_W-1:0] recip_q16(input int k);
    if (k <= 0) return '0;
    return EXP_RECIP_W'((65536 + k / 2) / k);
  endfunction

endpackage

// File: rtl/recip_rom.sv
// rtl/recip_rom.sv - round(2^16/k) lookup for Taylor term k, indexed by k-1
module recip_rom
  import replica_pkg::*;
(
  input  logic [$clog2(EXP_TERMS_MAX)-1:0] idx_i,
  output logic [EXP_RECIP_W-1:0]           recip_o
);

  always_comb begin
    recip_o = '0;
    case (idx_i)
      4'd0:  recip_o = 17'd65536;
      4'd1:  recip_o = 17'd32768;
      4'd2:  recip_o = 17'd21845;
      4'd3:  recip_o = 17'd16384;
      4'd4:  recip_o = 17'd13107;
      4'd5:  recip_o = 17'd10923;
      4'd6:  recip_o = 17'd9362;
      4'd7:  recip_o = 17'd8192;
      4'd8:  recip_o = 17'd7282;
      4'd9:  recip_o = 17'd6554;
      4'd10: recip_o = 17'd5958;
      4'd11: recip_o = 17'd5461;
      4'd12: recip_o = 17'd5041;
      4'd13: recip_o = 17'd4681;
      4'd14: recip_o = 17'd4369;
      4'd15: recip_o = 17'd4096;
      default: recip_o = '0;
    endcase
  end

endmodule

// File: rtl/opt_sequencer.sv
// rtl/opt_sequencer.sv - per-iteration command sequencer broadcasting opt/exp/exchange
// strobes to every replica node
module opt_sequencer
  import replica_pkg::*;
#(
  parameter int EXP_TERMS = 8,
  parameter int DIST_LAT  = 4,
  parameter int EXCH_LAT  = 4,
  parameter int ITER_W    = 24
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [ITER_W-1:0]      iter_num,
  input  logic                   abort,
  output logic                   busy,
  output logic                   done,
  output logic [ITER_W-1:0]      iter_cnt,
  output logic                   opt_run,
  output logic                   exchange_parity,
  output logic                   exp_init,
  output logic                   exp_run,
  output logic                   exp_fin,
  output logic [EXP_RECIP_W-1:0] exp_recip
);

  seq_state_t             state_q;
  logic [ITER_W-1:0]      remaining_q;
  logic [ITER_W-1:0]      iter_cnt_q;
  logic                   parity_q;
  logic [3:0]             dly_q;
  logic [4:0]             term_q;
  logic                   busy_q;
  logic                   done_q;
  logic                   opt_run_q;
  logic                   exp_init_q;
  logic                   exp_run_q;
  logic                   exp_fin_q;
  logic [EXP_RECIP_W-1:0] exp_recip_q;

  logic [$clog2(EXP_TERMS_MAX)-1:0] recip_idx;
  logic [EXP_RECIP_W-1:0]           recip_d;

  // Look up the term that will be presented next cycle: k=1 from EINIT, k=term_q+1 in ERUN.
  assign recip_idx = (state_q == ERUN) ? term_q[3:0] : '0;

  recip_rom u_recip_rom (
    .idx_i   (recip_idx),
    .recip_o (recip_d)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      remaining_q <= '0;
      iter_cnt_q  <= '0;
      parity_q    <= 1'b0;
      dly_q       <= '0;
      term_q      <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      opt_run_q   <= 1'b0;
      exp_init_q  <= 1'b0;
      exp_run_q   <= 1'b0;
      exp_fin_q   <= 1'b0;
      exp_recip_q <= '0;
    end else begin
      opt_run_q   <= 1'b0;
      exp_init_q  <= 1'b0;
      exp_run_q   <= 1'b0;
      exp_fin_q   <= 1'b0;
      exp_recip_q <= '0;
      done_q      <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            remaining_q <= iter_num;
            iter_cnt_q  <= '0;
            parity_q    <= 1'b0;
            busy_q      <= 1'b1;
            if (iter_num == '0) begin
              state_q <= CHECK;
            end else begin
              state_q   <= OPT;
              opt_run_q <= 1'b1;
            end
          end
        end
        OPT: begin
          state_q <= DIST;
          dly_q   <= 4'(DIST_LAT - 1);
        end
        DIST: begin
          if (dly_q == 4'd0) begin
            state_q    <= EINIT;
            exp_init_q <= 1'b1;
          end else begin
            dly_q <= dly_q - 4'd1;
          end
        end
        EINIT: begin
          state_q     <= ERUN;
          term_q      <= 5'd1;
          exp_run_q   <= 1'b1;
          exp_recip_q <= recip_d;
        end
        ERUN: begin
          if (term_q == 5'(EXP_TERMS)) begin
            state_q   <= EFIN;
            exp_fin_q <= 1'b1;
          end else begin
            term_q      <= term_q + 5'd1;
            exp_run_q   <= 1'b1;
            exp_recip_q <= recip_d;
          end
        end
        EFIN: begin
          state_q <= EXCH;
          dly_q   <= 4'(EXCH_LAT - 1);
        end
        EXCH: begin
          if (dly_q == 4'd0) begin
            // Bookkeeping lands on entry so done and the new count appear together in CHECK.
            state_q     <= CHECK;
            iter_cnt_q  <= iter_cnt_q + ITER_W'(1);
            remaining_q <= remaining_q - ITER_W'(1);
            parity_q    <= ~parity_q;
            done_q      <= (remaining_q == ITER_W'(1)) || abort;
          end else begin
            dly_q <= dly_q - 4'd1;
          end
        end
        CHECK: begin
          if (done_q) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else if (remaining_q == '0) begin
            done_q <= 1'b1;
          end else begin
            state_q   <= OPT;
            opt_run_q <= 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy            = busy_q;
  assign done            = done_q;
  assign iter_cnt        = iter_cnt_q;
  assign opt_run         = opt_run_q;
  assign exchange_parity = parity_q;
  assign exp_init        = exp_init_q;
  assign exp_run         = exp_run_q;
  assign exp_fin         = exp_fin_q;
  assign exp_recip       = exp_recip_q;

endmodule

// File: doc/opt_sequencer.md
Name: opt_sequencer

Overview:
- Per-iteration command sequencer that drives the shared control inputs of every replica node: opt_run, the exchange parity, and the exp_init/exp_run/exp_fin/exp_recip strobes of the Metropolis exp() series.
- Sits directly upstream of the node array and is broadcast to all nodes.
- Started by the host, runs a programmed number of iterations, then reports done.

Parameters:
- EXP_TERMS, 8: number of Taylor terms per acceptance test; legal range 1..16.
- DIST_LAT, 4: cycles waited after opt_run for the delta-distance pipeline; legal range 1..15.
- EXCH_LAT, 4: cycles waited for the replica-exchange phase; legal range 1..15.
- ITER_W, 24: width of the iteration count.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- start  in  1  one-cycle request; sampled only in IDLE
- iter_num  in  ITER_W  iteration count, latched on an accepted start
- abort  in  1  level; stop at the next iteration boundary
- busy  out  1  high in any state other than IDLE
- done  out  1  one-cycle pulse when the run ends
- iter_cnt  out  ITER_W  iterations completed in the current run
- opt_run  out  1  one-cycle opt strobe to the nodes
- exchange_parity  out  1  even/odd replica pairing; 0 on the first iteration, toggles every iteration
- exp_init  out  1  one-cycle strobe
- exp_run  out  1  high for EXP_TERMS consecutive cycles
- exp_fin  out  1  one-cycle strobe
- exp_recip  out  17  round(2^16/k) during exp_run term k; 0 otherwise

Behaviour:
- Reset (asynchronous assert, synchronous release):
  - state=IDLE.
  - All outputs 0, including iter_cnt and exchange_parity.
- States: IDLE, OPT, DIST, EINIT, ERUN, EFIN, EXCH, CHECK.
- IDLE, start=1:
  - latch iter_num into remaining; iter_cnt:=0; parity:=0.
  - If iter_num==0: go to CHECK, which produces the done pulse in the next cycle with no opt_run.
  - Otherwise go to OPT.
- Per iteration:
  - OPT, 1 cycle: opt_run=1.
  - DIST, DIST_LAT cycles: no strobes.
  - EINIT, 1 cycle: exp_init=1.
  - ERUN, EXP_TERMS cycles: exp_run=1, term counter k=1..EXP_TERMS, exp_recip=recip(k).
  - EFIN, 1 cycle: exp_fin=1.
  - EXCH, EXCH_LAT cycles: no strobes.
  - CHECK, 1 cycle: iter_cnt+=1, remaining-=1, parity toggles.
- Leaving CHECK:
  - If remaining==0 or abort==1: done=1 in the same cycle, then IDLE.
  - Otherwise go to OPT.
- Iteration period: 4+DIST_LAT+EXP_TERMS+EXCH_LAT cycles. With the defaults that is 20, so consecutive opt_run pulses are 20 cycles apart.
- Start timing: start accepted in cycle N gives opt_run in cycle N+1.
- start while busy is ignored: no relatch, no effect on the count.
- abort is never honoured mid-iteration, so node exp and exchange state always sees a complete init/run/fin sequence. abort in IDLE has no effect.
- Strobes are registered outputs and are mutually exclusive: at most one of opt_run, exp_init, exp_run, exp_fin is high in any cycle.
- exchange_parity is stable for the whole iteration and changes only in CHECK.
- iter_cnt holds its final value in IDLE until the next accepted start.
- Reset asserted mid-run: immediate return to IDLE with all outputs 0; no done pulse.
- Counter widths:
  - delay counter: 4 bits.
  - term counter: 5 bits.
  - remaining: ITER_W bits, no wrap, because it is checked before decrementing.

Decomposition:
- replica_pkg additions:
  - seq_state_t enum.
  - exp_recip_w=17.
  - EXP_TERMS_MAX=16.
  - function recip_q16(k) returning round(65536/k).
- Sub-module recip_rom: combinational 16-entry table indexed by k-1 (k-1=0..15). Values:
  - 65536, 32768, 21845, 16384
  - 13107, 10923, 9362, 8192
  - 7282, 6554, 5958, 5461
  - 5041, 4681, 4369, 4096
- Everything else stays in opt_sequencer.

Test Plan:
- Single iteration, defaults, iter_num=1, start in cycle 0:
  - opt_run in cycle 1.
  - exp_init in cycle 6.
  - exp_run in cycles 7-14, exp_recip 65536, 32768, 21845, 16384, 13107, 10923, 9362, 8192.
  - exp_fin in cycle 15.
  - done in cycle 20, iter_cnt=1, busy low from cycle 21.
- iter_num=3:
  - opt_run in cycles 1, 21, 41.
  - exchange_parity 0, 1, 0 across the three iterations.
  - done in cycle 60, iter_cnt=3.
- iter_num=0:
  - done in cycle 2, iter_cnt=0.
  - opt_run and exp strobes never asserted.
- abort raised in cycle 25 of a 10-iteration run:
  - iteration 2 completes with exp_fin in cycle 35.
  - done in cycle 40, iter_cnt=2.
- start pulsed in cycle 5 of an active run with iter_num=7: ignored; the run finishes with the original count.
- reset dropped low in cycle 10 (during ERUN):
  - all outputs 0 immediately, no done pulse.
  - after release, a new start gives opt_run one cycle later.
